// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the word-addressed memory slave and its wait-state helper.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } slv_state_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam int WCNT_W = 8;

   // Only NONSEQ and SEQ carry a real transfer.
   function automatic logic is_active(input htrans_t t);
      logic act;
      case (t)
         HTRANS_NONSEQ: act = 1'b1;
         HTRANS_SEQ:    act = 1'b1;
         default:       act = 1'b0;
      endcase
      return act;
   endfunction

endpackage

// File: rtl/ahb_wait_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that advances only when stepped.
module ahb_wait_lfsr (
   input  logic        clk,
   input  logic        resetn,
   input  logic        step,
   output logic [15:0] value
);

   logic [15:0] lfsr_q;
   logic        fb;

   // feedback tap combination
   always_comb begin
      fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   end

   // shift register, reseeded on reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         lfsr_q <= 16'hACE1;
      end else if (step) begin
         lfsr_q <= {lfsr_q[14:0], fb};
      end else begin
         lfsr_q <= lfsr_q;
      end
   end

   assign value = lfsr_q;

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-addressed SRAM slave with wait states and two-cycle ERROR responses.
// Optional AHB_SLV_RANDOM_WAIT_EN: per-transfer wait count taken from an LFSR instead of WAIT_STATES.
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    MEM_DEPTH   = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0,
   parameter int                    MAX_WAIT    = 3
) (
   input  logic                  clk,
   input  logic                  HRESETn,
   input  logic                  HSELAHB,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADY,
   output logic                  HRESP
);

   localparam int                    IDX_W     = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

   slv_state_t              state;
   logic                    ready_q;
   logic                    resp_q;
   logic [IDX_W-1:0]        idx_q;
   logic                    write_q;
   logic [WCNT_W-1:0]       wait_cnt;
   logic [WCNT_W-1:0]       wait_n;
   logic [ADDR_WIDTH-1:0]   offset;
   logic                    addr_bad;
   logic                    accept;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

   // address-phase decode; the unsigned compare also catches addresses below BASE_ADDR
   always_comb begin
      offset   = HADDR - BASE_ADDR;
      addr_bad = (HADDR[1:0] != 2'b00) || (offset >= MEM_BYTES);
      accept   = HSELAHB && is_active(htrans_t'(HTRANS)) && ready_q;
   end

`ifdef AHB_SLV_RANDOM_WAIT_EN
   logic [15:0] lfsr;

   ahb_wait_lfsr u_lfsr (
      .clk    (clk),
      .resetn (HRESETn),
      .step   (accept),
      .value  (lfsr)
   );

   assign wait_n = WCNT_W'(lfsr % 16'(MAX_WAIT + 1));
`else
   assign wait_n = WCNT_W'(WAIT_STATES);
`endif

   // transfer FSM; HREADY/HRESP are registered alongside the state
   always_ff @(posedge clk) begin
      if (!HRESETn) begin
         state    <= ST_IDLE;
         ready_q  <= 1'b1;
         resp_q   <= HRESP_OKAY;
         idx_q    <= '0;
         write_q  <= 1'b0;
         wait_cnt <= '0;
      end else begin
         case (state)
            ST_WAIT: begin
               if (wait_cnt <= WCNT_W'(1)) begin
                  state    <= ST_DATA;
                  ready_q  <= 1'b1;
                  resp_q   <= HRESP_OKAY;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt - WCNT_W'(1);
               end
            end
            ST_ERR1: begin
               state   <= ST_ERR2;
               ready_q <= 1'b1;
               resp_q  <= HRESP_ERROR;
            end
            // IDLE, DATA and ERR2 all have HREADY high and may take a new address phase
            default: begin
               if (accept) begin
                  idx_q   <= offset[IDX_W+1:2];
                  write_q <= HWRITE;
                  if (addr_bad) begin
                     state   <= ST_ERR1;
                     ready_q <= 1'b0;
                     resp_q  <= HRESP_ERROR;
                  end else if (wait_n != WCNT_W'(0)) begin
                     state    <= ST_WAIT;
                     ready_q  <= 1'b0;
                     resp_q   <= HRESP_OKAY;
                     wait_cnt <= wait_n;
                  end else begin
                     state   <= ST_DATA;
                     ready_q <= 1'b1;
                     resp_q  <= HRESP_OKAY;
                  end
               end else begin
                  state   <= ST_IDLE;
                  ready_q <= 1'b1;
                  resp_q  <= HRESP_OKAY;
               end
            end
         endcase
      end
   end

   // write commits at the end of the DATA cycle; a reset in that cycle drops it
   always_ff @(posedge clk) begin
      if (HRESETn && (state == ST_DATA) && write_q) begin
         mem[idx_q] <= HWDATA;
      end
   end

   // read data is only driven during a read data phase
   always_comb begin
      rdata = '0;
      if ((state == ST_DATA) && !write_q) begin
         rdata = mem[idx_q];
      end else begin
         rdata = '0;
      end
   end

   assign HRDATA = rdata;
   assign HREADY = ready_q;
   assign HRESP  = resp_q;

endmodule
